// File: rtl/scaled_background.sv
// Windowed, rationally upscaled palette-image renderer with per-frame fade-in.
// Three pix_ce-gated stages: DDA address generation, ROM capture, palette/fade colour.
module scaled_background #(
  parameter int unsigned IMG_W       = 400,
  parameter int unsigned IMG_H       = 300,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned SCALE_NUM   = 5,
  parameter int unsigned SCALE_DEN   = 8,
  parameter int unsigned WIN_X0      = 0,
  parameter int unsigned WIN_Y0      = 0,
  parameter int unsigned WIN_W       = 640,
  parameter int unsigned WIN_H       = 480,
  parameter bit          FADE_EN     = 1'b1,
  parameter int unsigned FADE_FRAMES = 4,
  parameter int unsigned AW          = $clog2(IMG_W * IMG_H)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     pix_ce,
  input  logic                     enable,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic [$clog2(IMG_W)-1:0] scroll_x,
  output logic [AW-1:0]            rom_addr,
  input  logic [IDX_W-1:0]         rom_data,
  input  logic                     pal_we,
  input  logic [IDX_W-1:0]         pal_waddr,
  input  logic [23:0]              pal_wdata,
  output logic                     is_image,
  output logic [23:0]              color
);

  localparam int unsigned XW       = $clog2(IMG_W);
  localparam int unsigned YW       = $clog2(IMG_H);
  localparam int unsigned AccW     = $clog2(SCALE_DEN) + 1;
  localparam int unsigned FcW      = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam int unsigned PalDepth = 2 ** IDX_W;

  typedef enum logic [1:0] {StOff, StRamp, StFull} fade_state_e;

  // Stage 1 state
  logic [AccW-1:0] xacc_q, xacc_d, yacc_q, yacc_d, xsum, ysum;
  logic [XW-1:0]   src_x_q, src_x_d, scroll_l_q, scroll_l_d, scroll_in;
  logic [YW-1:0]   src_y_q, src_y_d;
  logic [9:0]      prev_y_q;
  logic [AW-1:0]   addr_d;
  logic            win_s1_q;

  // Stage 2/3 state
  logic [IDX_W-1:0] idx_q;
  logic             win_s2_q;
  logic [23:0]      pal [PalDepth];
  logic [23:0]      pal_rd, color_d;

  // Fade
  fade_state_e state_q, state_d;
  logic [4:0]  level_q, level_d, fade_level;
  logic [FcW-1:0] fcnt_q, fcnt_d;

  logic x_in, y_in, in_win, x_origin, y_origin, frame_pos, frame_start, new_line;

  // Unsigned wrap makes coordinates left of / above the window fail the range test.
  assign x_in        = ((32'(DrawX) - WIN_X0) < WIN_W);
  assign y_in        = ((32'(DrawY) - WIN_Y0) < WIN_H);
  assign in_win      = enable & x_in & y_in;
  assign x_origin    = (32'(DrawX) == WIN_X0);
  assign y_origin    = (32'(DrawY) == WIN_Y0);
  assign frame_pos   = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign frame_start = pix_ce & frame_pos;
  assign new_line    = (DrawY != prev_y_q);
  assign scroll_in   = (32'(scroll_x) >= IMG_W) ? '0 : scroll_x;

  always_comb begin
    scroll_l_d = frame_pos ? scroll_in : scroll_l_q;
    xacc_d     = xacc_q;
    src_x_d    = src_x_q;
    xsum       = xacc_q + AccW'(SCALE_NUM);
    if (x_origin) begin
      xacc_d  = '0;
      src_x_d = scroll_l_d;
    end else if (in_win) begin
      if (xsum >= AccW'(SCALE_DEN)) begin
        xacc_d  = xsum - AccW'(SCALE_DEN);
        src_x_d = (src_x_q == XW'(IMG_W - 1)) ? '0 : src_x_q + 1'b1;
      end else begin
        xacc_d = xsum;
      end
    end
  end

  always_comb begin
    yacc_d  = yacc_q;
    src_y_d = src_y_q;
    ysum    = yacc_q + AccW'(SCALE_NUM);
    if (new_line) begin
      if (y_origin) begin
        yacc_d  = '0;
        src_y_d = '0;
      end else if (enable && y_in) begin
        if (ysum >= AccW'(SCALE_DEN)) begin
          yacc_d = ysum - AccW'(SCALE_DEN);
          if (src_y_q != YW'(IMG_H - 1)) src_y_d = src_y_q + 1'b1;
        end else begin
          yacc_d = ysum;
        end
      end
    end
  end

  always_comb begin
    addr_d = rom_addr;
    if (in_win) addr_d = AW'(src_y_d * IMG_W) + AW'(src_x_d);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      xacc_q     <= '0;
      yacc_q     <= '0;
      src_x_q    <= '0;
      src_y_q    <= '0;
      prev_y_q   <= '0;
      scroll_l_q <= '0;
      win_s1_q   <= 1'b0;
      rom_addr   <= '0;
      idx_q      <= '0;
      win_s2_q   <= 1'b0;
      is_image   <= 1'b0;
      color      <= '0;
    end else if (pix_ce) begin
      xacc_q     <= xacc_d;
      yacc_q     <= yacc_d;
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      prev_y_q   <= DrawY;
      scroll_l_q <= scroll_l_d;
      win_s1_q   <= in_win;
      rom_addr   <= addr_d;
      idx_q      <= rom_data;
      win_s2_q   <= win_s1_q;
      is_image   <= win_s2_q;
      color      <= color_d;
    end
  end

  // Palette survives Reset; a same-cycle write is seen by the next lookup only.
  always_ff @(posedge Clk) begin
    if (pal_we) pal[pal_waddr] <= pal_wdata;
  end

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [4:0] l);
    logic [11:0] p;
    p = 12'(c) * 12'(l);
    return 8'(p >> 4);
  endfunction

  always_comb begin
    pal_rd  = pal[idx_q];
    color_d = '0;
    if (win_s2_q) begin
      color_d = {scale_ch(pal_rd[23:16], fade_level), scale_ch(pal_rd[15:8], fade_level),
                 scale_ch(pal_rd[7:0], fade_level)};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StOff;
      level_q <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    fcnt_d  = fcnt_q;
    if (!FADE_EN) begin
      state_d = StFull;
      level_d = 5'd16;
      fcnt_d  = '0;
    end else if (!enable) begin
      state_d = StOff;
      level_d = '0;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        StOff: begin
          state_d = StRamp;
          level_d = '0;
          fcnt_d  = '0;
        end
        StRamp: begin
          if (frame_start) begin
            if (fcnt_q == FcW'(FADE_FRAMES - 1)) begin
              fcnt_d  = '0;
              level_d = level_q + 5'd1;
              if (level_q == 5'd15) state_d = StFull;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end
        StFull:  level_d = 5'd16;
        default: state_d = StOff;
      endcase
    end
  end

  // Dropping enable blanks brightness without waiting for the state register.
  always_comb begin
    fade_level = level_q;
    if (!FADE_EN)     fade_level = 5'd16;
    else if (!enable) fade_level = '0;
  end

endmodule

// File: tb/tb_scaled_background.sv
// Scoreboard bench for scaled_background: closed-form address model, synchronous ROM
// model, palette shadow and fade-level model.
module tb_scaled_background;

  logic        Clk, Reset, pix_ce, enable, pal_we;
  logic [9:0]  DrawX, DrawY;
  logic [8:0]  scroll_x;
  logic [16:0] rom_addr;
  logic [3:0]  rom_data, pal_waddr;
  logic [23:0] pal_wdata, color;
  logic        is_image;

  scaled_background dut (
    .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce), .enable(enable), .DrawX(DrawX), .DrawY(DrawY),
    .scroll_x(scroll_x), .rom_addr(rom_addr), .rom_data(rom_data), .pal_we(pal_we),
    .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .is_image(is_image), .color(color)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom_f(input logic [16:0] a);
    return a[3:0] ^ a[9:6];
  endfunction

  always @(posedge Clk) rom_data <= rom_f(rom_addr);

  typedef struct packed {logic win; logic known; logic [3:0] idx;} exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  int exp_addr, scroll_m, f_st, exp_level, fcnt;
  bit addr_known, did_half;
  logic [23:0] tb_pal [16];
  logic [23:0] old3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] scale(input logic [23:0] c, input int l);
    int r, g, b;
    r = int'(c[23:16]) * l / 16;
    g = int'(c[15:8]) * l / 16;
    b = int'(c[7:0]) * l / 16;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '0;
    sb.delete();
    sb.push_back(z);
    sb.push_back(z);
    exp_addr = 0; addr_known = 0; scroll_m = 0;
    f_st = 0; exp_level = 0; fcnt = 0;
  endtask

  task automatic pal_write(input int a, input logic [23:0] d);
    pal_we = 1'b1; pal_waddr = 4'(a); pal_wdata = d;
    @(posedge Clk); #1;
    pal_we = 1'b0;
    tb_pal[a] = d;
  endtask

  // One pixel strobe followed by one idle cycle; a pending pal_we lands on the strobe edge.
  task automatic strobe(input int x, input int y, input bit en, input bit rst);
    bit fs, win;
    exp_t e, p;
    int ey, lvl_now;
    DrawX = 10'(x); DrawY = 10'(y); enable = en; Reset = rst; pix_ce = 1'b1;
    fs  = (x == 0 && y == 0);
    win = en && x < 640 && y < 480;
    @(posedge Clk); #1;
    pix_ce = 1'b0; Reset = 1'b0;
    if (rst) begin
      check("rst_addr", 32'(rom_addr), 0);
      check("rst_image", 32'(is_image), 0);
      check("rst_color", 32'(color), 0);
      model_reset();
    end else begin
      if (fs) begin
        scroll_m = (scroll_x >= 400) ? 0 : int'(scroll_x);
        addr_known = 1;
      end
      if (win) begin
        ey = y * 5 / 8;
        if (ey > 299) ey = 299;
        exp_addr = ey * 400 + (scroll_m + x * 5 / 8) % 400;
      end
      if (addr_known) check("rom_addr", 32'(rom_addr), 32'(exp_addr));
      e.win = win; e.known = addr_known; e.idx = rom_f(17'(exp_addr));
      sb.push_back(e);
      if (sb.size() == 3) begin
        p = sb.pop_front();
        lvl_now = en ? exp_level : 0;
        check("is_image", 32'(is_image), 32'(p.win));
        if (p.known || !p.win)
          check("color", 32'(color), p.win ? 32'(scale(tb_pal[p.idx], lvl_now)) : 0);
      end
      if (pal_we) tb_pal[pal_waddr] = pal_wdata;
      if (!en) begin
        f_st = 0; exp_level = 0; fcnt = 0;
      end else if (f_st == 0) begin
        f_st = 1; exp_level = 0; fcnt = 0;
      end else if (f_st == 1 && fs) begin
        if (fcnt == 3) begin
          fcnt = 0;
          exp_level++;
          if (exp_level == 16) f_st = 2;
        end else begin
          fcnt++;
        end
      end
    end
    pal_we = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; pix_ce = 1'b0; enable = 1'b0; pal_we = 1'b0; DrawX = '0; DrawY = '0;
    scroll_x = '0; pal_waddr = '0; pal_wdata = '0; did_half = 0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("init_addr", 32'(rom_addr), 0);
    check("init_image", 32'(is_image), 0);
    check("init_color", 32'(color), 0);
    model_reset();

    // Fade ramp with a white palette: fake frames of four strobes each.
    for (int i = 0; i < 16; i++) pal_write(i, 24'hFFFFFF);
    for (int f = 0; f < 66; f++) begin
      for (int x = 0; x < 4; x++) strobe(x, 0, 1, 0);
      if (exp_level == 8 && !did_half) begin
        check("fade_half", 32'(color), 32'h7F7F7F);
        did_half = 1;
      end
    end
    check("fade_full", 32'(color), 32'hFFFFFF);

    // Distinct palette, then row 0 with a palette write colliding with a read of entry 3.
    for (int i = 0; i < 16; i++)
      pal_write(i, {8'(i * 16 + 1), 8'(200 - i * 7), 8'(i * 3 + 40)});
    old3 = tb_pal[3];
    for (int x = 0; x < 10; x++) begin
      if (x == 7) begin
        pal_we = 1'b1; pal_waddr = 4'd3; pal_wdata = 24'h123456;
      end
      strobe(x, 0, 1, 0);
      if (x == 7) check("pal_old", 32'(color), 32'(old3));
      if (x == 8) check("pal_new", 32'(color), 32'h123456);
    end

    // Scroll latched at frame start, wraps, and ignores a mid-frame change.
    scroll_x = 9'd398;
    for (int x = 0; x < 5; x++) strobe(x, 0, 1, 0);
    check("scroll_wrap", 32'(rom_addr), 0);
    scroll_x = 9'd10;
    for (int x = 5; x < 8; x++) strobe(x, 0, 1, 0);
    scroll_x = 9'd0;

    // Whole-height pass, then the last line to the bottom-right corner and past it.
    for (int y = 0; y < 480; y++) strobe(0, y, 1, 0);
    for (int x = 1; x < 640; x++) strobe(x, 479, 1, 0);
    check("corner_addr", 32'(rom_addr), 32'd119999);
    for (int x = 640; x < 643; x++) strobe(x, 479, 1, 0);
    check("outside_image", 32'(is_image), 0);
    check("outside_color", 32'(color), 0);

    // Enable drop mid-line: colour blanks at once, is_image trails by the pipeline.
    for (int x = 0; x < 3; x++) strobe(x, 0, 1, 0);
    strobe(3, 0, 0, 0);
    check("drop_color", 32'(color), 0);
    strobe(4, 0, 0, 0);
    strobe(5, 0, 0, 0);
    check("drop_image", 32'(is_image), 0);

    // Reset mid-line, resume mid-frame, then a clean frame.
    for (int x = 0; x < 6; x++) strobe(x, 0, 1, 0);
    strobe(6, 0, 1, 1);
    for (int x = 7; x < 10; x++) strobe(x, 0, 1, 0);
    for (int x = 0; x < 4; x++) strobe(x, 1, 1, 0);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 8; x++) strobe(x, y, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scaled_background.md
# scaled_background

Parametrised full-screen or windowed image renderer: the next generation of the title-page background path. It maps VGA draw coordinates into a stored palette-indexed image at a rational upscale factor, using incremental DDA counters instead of multiply/divide. It fetches the index from an external synchronous ROM, resolves it through a writable palette, and applies an optional per-frame fade-in. It sits between the VGA controller and the color mapper, replacing per-page background/ROM pairs.

## Interface
- IMG_W, 400: source image width in pixels.
- IMG_H, 300: source image height in pixels.
- IDX_W, 4: palette index width; palette depth is 2**IDX_W.
- SCALE_NUM, 5: source pixels advanced per SCALE_DEN screen pixels; 1 ≤ SCALE_NUM ≤ SCALE_DEN.
- SCALE_DEN, 8: see SCALE_NUM.
- WIN_X0, WIN_Y0, 0 / 0: top-left screen corner of the display window.
- WIN_W, WIN_H, 640 / 480: window size in screen pixels.
- FADE_EN, 1: 1 enables fade-in; 0 forces full brightness.
- FADE_FRAMES, 4: frames per brightness step.
- AW, $clog2(IMG_W*IMG_H): ROM address width.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: synchronous, active-high.
- pix_ce, in, 1: pixel strobe. The pipeline advances only on Clk edges where pix_ce=1. Consecutive strobes are separated by at least one low cycle.
- enable, in, 1: page active (status decode done upstream).
- DrawX, DrawY, in, 10 each: current pixel coordinates.
- scroll_x, in, $clog2(IMG_W): horizontal source offset.
- rom_addr, out, AW: image ROM read address, registered.
- rom_data, in, IDX_W: ROM output, valid one Clk after rom_addr changes.
- pal_we, in, 1: palette write strobe.
- pal_waddr, in, IDX_W: palette write address.
- pal_wdata, in, 24: palette write data, RGB 8:8:8.
- is_image, out, 1: current output pixel belongs to the window.
- color, out, 24: RGB output.

## Operation
- Stage 1 (address generation), on pix_ce:
  - in_win = enable & DrawX in [WIN_X0, WIN_X0+WIN_W) & DrawY in [WIN_Y0, WIN_Y0+WIN_H).
  - scroll_x is latched into scroll_l on the frame-start strobe (DrawX=0, DrawY=0). Latched values ≥ IMG_W become 0.
- Horizontal DDA (xacc, src_x):
  - DrawX=WIN_X0: xacc=0, src_x=scroll_l.
  - Otherwise, inside the window: xacc+=SCALE_NUM. If the result is ≥ SCALE_DEN, subtract SCALE_DEN and increment src_x. src_x wraps from IMG_W-1 to 0.
- Vertical DDA (yacc, src_y):
  - Steps only on the first strobe of a new line, detected as DrawY ≠ registered previous DrawY.
  - DrawY=WIN_Y0: yacc=0, src_y=0.
  - Otherwise, inside the window: same add/compare/subtract rule. src_y saturates at IMG_H-1.
- Result: screen pixel offset p maps to source floor(p·NUM/DEN), plus scroll on the x axis.
- rom_addr = src_y·IMG_W + src_x. The address is built from the values the DDAs take on this strobe. Outside the window, rom_addr holds.
- Stage 2, on the next pix_ce: capture rom_data and in_win.
- Stage 3, on the next pix_ce:
  - color = (pal[idx] channel · level) >> 4, per channel, where level is 0..16.
  - is_image = in_win from stage 2. When is_image=0, color=0.
- Fade FSM, states OFF, RAMP, FULL:
  - OFF→RAMP when enable is sampled 1, with level=0.
  - In RAMP, level increments every FADE_FRAMES frame starts; level reaching 16 moves to FULL.
  - Any state→OFF when enable=0, with level forced to 0.
  - FADE_EN=0: level is always 16 and the FSM stays in FULL.
- Palette:
  - Writes on Clk when pal_we=1, independent of pix_ce.
  - A write and a stage-3 read of the same entry in the same cycle returns the old value.
  - Palette contents are not affected by Reset.

## Timing
- Latency: color/is_image reflect the DrawX/DrawY sampled 3 pix_ce strobes earlier. The VGA controller's blank/sync delay is matched upstream.
- Reset values: rom_addr=0, is_image=0, color=0, all DDA and pipeline registers 0, scroll_l=0, fade state OFF, level=0.
- Reset mid-frame: outputs are 0 from the next edge. Correct addressing resumes at the next window line start. Correct rows resume from the next frame's WIN_Y0.
- enable falling mid-line: is_image drops 3 strobes later and level is 0 immediately.
- Changes to scroll_x mid-frame are ignored until the next frame start.
- No pix_ce: all state holds except palette writes and the Reset response.

## Test plan
- NUM=5, DEN=8, scroll 0, row DrawY=0, DrawX=0..7 → rom_addr sequence 0,0,1,1,2,3,3,4. Each color appears 3 strobes after its DrawX.
- DrawX=639, DrawY=479 → rom_addr=119999 (src 399,299). DrawX=640 → is_image=0, color=0.
- scroll_x=398 latched at frame start, DrawY=0, DrawX=0..4 → src_x 398,398,399,399,0 (wrap).
- FADE_FRAMES=4, palette entry 0xFFFFFF, enable rises → level steps 0,1,…,16 every 4 frames. At level 8, color is 0x7F7F7F. FULL is reached after 64 frames. Dropping enable gives level 0.
- Palette write of entry 3 = 0x123456 in the same cycle stage 3 reads index 3 → old color output. Next lookup outputs 0x123456.
- Reset asserted mid-line with pix_ce running → is_image=0, color=0 and rom_addr=0 on the next edge. After release, the next frame's output matches the golden model pixel for pixel.
